// File: rtl/rst_seq_pkg.sv
// Shared types and limits for the reset sequencer: FSM states, counter sizing
// and the legal parameter ranges.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_STRETCH = 2'd1,
    ST_RELEASE = 2'd2,
    ST_RUN     = 2'd3
  } rst_state_e;

  localparam int STAGES_MIN = 2;
  localparam int STAGES_MAX = 4;
  localparam int NUM_CH_MIN = 1;
  localparam int NUM_CH_MAX = 8;
  localparam int CNT_MIN    = 1;
  localparam int CNT_MAX    = 255;

  // Wide enough to hold the larger of the two reload values.
  function automatic int cnt_width(input int min_assert, input int gap);
    int m;
    m = (min_assert > gap) ? min_assert : gap;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/rst_seq_sync_if.sv
// Software reset request in, sequenced channel resets and done flag out.
interface rst_seq_sync_if #(
  parameter int NUM_CH = 4
);
  logic              sw_rst_req;
  logic [NUM_CH-1:0] rst_n_out;
  logic              rst_done;

  modport master (output sw_rst_req, input  rst_n_out, input  rst_done);
  modport slave  (input  sw_rst_req, output rst_n_out, output rst_done);
endinterface

// File: rtl/rst_sync_chain.sv
// Async-assert / sync-release reset synchronizer, STAGES flops deep.
module rst_sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic async_rst_n,
  output logic sync_rst_n
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) sync_q <= '0;
    else              sync_q <= {sync_q[STAGES-2:0], 1'b1};
  end

  assign sync_rst_n = sync_q[STAGES-1];

endmodule

// File: rtl/rst_seq_sync.sv
// Reset sequencer: synchronizes async_rst_n, stretches reset for MIN_ASSERT
// cycles, then releases NUM_CH channels in index order GAP cycles apart.
module rst_seq_sync
  import rst_seq_pkg::*;
#(
  parameter int STAGES     = 2,
  parameter int NUM_CH     = 4,
  parameter int MIN_ASSERT = 8,
  parameter int GAP        = 16
) (
  input  logic           clk,
  input  logic           async_rst_n,
  rst_seq_sync_if.slave  rst_if
);

  localparam int CNT_W = cnt_width(MIN_ASSERT, GAP);
  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CNT_W-1:0] MIN_LD   = CNT_W'(MIN_ASSERT);
  localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);

  logic sync_rst_n;

  rst_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [NUM_CH-1:0] rst_n_q, rst_n_d;
  logic              done_q, done_d;
  logic              sw_q;

  rst_sync_chain #(.STAGES(STAGES)) u_sync (
    .clk         (clk),
    .async_rst_n (async_rst_n),
    .sync_rst_n  (sync_rst_n)
  );

  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      state_q <= ST_ASSERT;
      cnt_q   <= '0;
      idx_q   <= '0;
      rst_n_q <= '0;
      done_q  <= 1'b0;
      sw_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rst_n_q <= rst_n_d;
      done_q  <= done_d;
      sw_q    <= rst_if.sw_rst_req;
    end
  end

  // The counter expires on the edge where it would reach zero, so each
  // release lands exactly MIN_ASSERT / GAP edges after the reload edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rst_n_d = rst_n_q;
    done_d  = done_q;
    if (rst_if.sw_rst_req) begin
      state_d = ST_STRETCH;
      cnt_d   = MIN_LD;
      idx_d   = '0;
      rst_n_d = '0;
      done_d  = 1'b0;
    end else begin
      case (state_q)
        ST_ASSERT: begin
          if (sync_rst_n) begin
            state_d = ST_STRETCH;
            cnt_d   = MIN_LD;
          end
        end
        ST_STRETCH: begin
          // First low edge after a sw request stands in for the reload edge.
          if (!sw_q) begin
            if (cnt_q <= CNT_ONE) begin
              rst_n_d[0] = 1'b1;
              cnt_d      = GAP_LD;
              idx_d      = IDX_ONE;
              state_d    = (NUM_CH == 1) ? ST_RUN : ST_RELEASE;
            end else begin
              cnt_d = cnt_q - CNT_ONE;
            end
          end
        end
        ST_RELEASE: begin
          if (cnt_q <= CNT_ONE) begin
            rst_n_d[idx_q] = 1'b1;
            cnt_d          = GAP_LD;
            idx_d          = idx_q + IDX_ONE;
            if (idx_q == LAST_IDX) state_d = ST_RUN;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        ST_RUN:  done_d  = 1'b1;
        default: state_d = ST_ASSERT;
      endcase
    end
  end

  assign rst_if.rst_n_out = rst_n_q;
  assign rst_if.rst_done  = done_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_order
    if (i > 0) begin : g_prev
      a_in_order: assert property (@(posedge clk) disable iff (!async_rst_n)
        $rose(rst_n_q[i]) |-> $past(rst_n_q[i-1]));
    end
    a_not_after_done: assert property (@(posedge clk) disable iff (!async_rst_n)
      $rose(rst_n_q[i]) |-> !$past(done_q));
  end

endmodule

// File: tb/tb_rst_seq_sync.sv
// Directed bench: default config (a) and STAGES=3/NUM_CH=1/MIN=1/GAP=1 (b)
// share clock and async reset; release edges are hand-computed per window.
module tb_rst_seq_sync;

  logic clk;
  logic async_rst_n;
  int   checks = 0;
  int   fails  = 0;

  rst_seq_sync_if #(.NUM_CH(4)) a_if ();
  rst_seq_sync_if #(.NUM_CH(1)) b_if ();

  rst_seq_sync #(.STAGES(2), .NUM_CH(4), .MIN_ASSERT(8), .GAP(16)) u_a (
    .clk         (clk),
    .async_rst_n (async_rst_n),
    .rst_if      (a_if)
  );

  rst_seq_sync #(.STAGES(3), .NUM_CH(1), .MIN_ASSERT(1), .GAP(1)) u_b (
    .clk         (clk),
    .async_rst_n (async_rst_n),
    .rst_if      (b_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // k counts edges from the window start; a channel i is expected high from
  // edge r0+16*i, done from edge dn. a_sw drops after the sample at k=sw_n-1.
  task automatic window(input string tag, input int n, input int r0, input int dn,
                        input int br0, input int bdn, input int sw_n);
    logic [3:0] ea;
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      ea = '0;
      for (int i = 0; i < 4; i++) if (k >= r0 + 16*i) ea[i] = 1'b1;
      chk($sformatf("%s_a_out@%0d", tag, k), 8'(a_if.rst_n_out), 8'(ea));
      chk($sformatf("%s_a_done@%0d", tag, k), 8'(a_if.rst_done), 8'(k >= dn));
      chk($sformatf("%s_b_out@%0d", tag, k), 8'(b_if.rst_n_out), 8'(k >= br0));
      chk($sformatf("%s_b_done@%0d", tag, k), 8'(b_if.rst_done), 8'(k >= bdn));
      if (k == sw_n - 1) a_if.sw_rst_req = 1'b0;
    end
  endtask

  initial begin
    async_rst_n     = 1'b0;
    a_if.sw_rst_req = 1'b0;
    b_if.sw_rst_req = 1'b0;
    #1;
    chk("rst_a_out", 8'(a_if.rst_n_out), 8'h00);
    chk("rst_a_done", 8'(a_if.rst_done), 8'h00);
    chk("rst_b_out", 8'(b_if.rst_n_out), 8'h00);
    chk("rst_b_done", 8'(b_if.rst_done), 8'h00);

    // sw request while async reset is held: async wins, outputs stay low
    a_if.sw_rst_req = 1'b1;
    b_if.sw_rst_req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk($sformatf("swrst_a_out@%0d", k), 8'(a_if.rst_n_out), 8'h00);
      chk($sformatf("swrst_b_out@%0d", k), 8'(b_if.rst_n_out), 8'h00);
    end
    a_if.sw_rst_req = 1'b0;
    b_if.sw_rst_req = 1'b0;

    // power-on sequence: ch0 @10, ch1 @26, ch2 @42, ch3 @58, done @59; b: 4/5
    @(negedge clk);
    async_rst_n = 1'b1;
    window("pon", 62, 10, 59, 4, 5, 0);

    // sw reset in RUN, high for 5 edges: ch0 8 edges after first low sample
    a_if.sw_rst_req = 1'b1;
    window("sw5", 66, 13, 62, -100, -100, 5);

    // one-edge sw reset to reach RELEASE with ch0/ch1 up, then async pulse
    a_if.sw_rst_req = 1'b1;
    window("sw1", 31, 9, 1000, -100, -100, 1);
    #1 async_rst_n = 1'b0;
    #1;
    chk("pulse_a_out", 8'(a_if.rst_n_out), 8'h00);
    chk("pulse_a_done", 8'(a_if.rst_done), 8'h00);
    chk("pulse_b_out", 8'(b_if.rst_n_out), 8'h00);
    chk("pulse_b_done", 8'(b_if.rst_done), 8'h00);
    #2 async_rst_n = 1'b1;
    window("rerun", 62, 10, 59, 4, 5, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
